cim_neuron_array: RTL and testbench

CIM_NEURON_ARRAY -- requirements
Module: cim_neuron_array

---
 rtl/cim_neuron_array_pkg.sv | 42 ++++
 rtl/cim_neuron_array_cell.sv | 113 +++++++++++
 rtl/cim_neuron_array.sv | 105 ++++++++++
 tb/tb_cim_neuron_array.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_neuron_array_pkg.sv
// Shared types and helpers for the compute-in-memory spiking neuron array:
// FSM state encoding, per-neuron config field layout, sign-extend and saturate.
package cim_neuron_array_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INT  = 3'd1,
        ST_LEAK = 3'd2,
        ST_CMP  = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    // Each neuron's config field is {enb, vth}: vth in the low V_W bits, enb above it.
    localparam int NCFG_VTH_LSB = 0;

    function automatic int ncfg_enb_bit(input int v_w);
        return v_w;
    endfunction

    function automatic int ncfg_field_w(input int v_w);
        return v_w + 1;
    endfunction

    function automatic int sext(input logic [31:0] raw, input int w);
        logic [31:0] t;
        t = raw << (32 - w);
        return $signed(t) >>> (32 - w);
    endfunction

    function automatic int sat(input int x, input int vmax);
        int r;
        if (x > vmax) begin
            r = vmax;
        end else if (x < -vmax) begin
            r = -vmax;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/cim_neuron_array_cell.sv
// One neuron: membrane potential, refractory counter, saturating integrate,
// leak and threshold compare, sequenced by the array FSM state.
module cim_neuron_cell
    import cim_neuron_array_pkg::*;
#(
    parameter int DV_W  = 6,
    parameter int V_W   = 7,
    parameter int REF_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pd,
    input  logic              clr,
    input  state_t            st,
    input  logic              tile_valid,
    input  logic [V_W:0]      cfg,
    input  logic              swp,
    input  logic [DV_W-1:0]   dv,
    input  logic [2:0]        leak,
    input  logic [REF_W-1:0]  ref_len,
    output logic              spike
);

    localparam int VMAX    = (1 << (V_W - 1)) - 1;
    localparam int ENB_BIT = ncfg_enb_bit(V_W);

    logic signed [V_W-1:0] v_r;
    logic signed [V_W-1:0] v_nx_s;
    logic signed [V_W-1:0] vth_s;
    logic signed [V_W-1:0] sum_sat_s;
    logic signed [V_W-1:0] leak_dv_s;
    logic [REF_W-1:0]      ref_r;
    logic [REF_W-1:0]      ref_nx_s;
    logic                  spike_r;
    logic                  spike_nx_s;
    logic                  enb_s;
    logic                  fire_s;

    assign enb_s     = cfg[ENB_BIT];
    assign vth_s     = $signed(cfg[NCFG_VTH_LSB +: V_W]);
    assign sum_sat_s = V_W'(sat(int'(v_r) + sext(32'(dv), DV_W), VMAX));
    assign leak_dv_s = v_r >>> leak;
    assign fire_s    = swp ? (v_r <= vth_s) : (v_r >= vth_s);
    assign spike     = spike_r;

    // Next-state of potential, refractory count and spike for the current FSM phase.
    always_comb begin
        v_nx_s     = v_r;
        ref_nx_s   = ref_r;
        spike_nx_s = spike_r;
        case (st)
            ST_IDLE: begin
                if (clr) begin
                    v_nx_s   = {V_W{1'b0}};
                    ref_nx_s = {REF_W{1'b0}};
                end else begin
                    v_nx_s = v_r;
                end
            end
            ST_INT: begin
                if (tile_valid && (ref_r == {REF_W{1'b0}})) begin
                    v_nx_s = sum_sat_s;
                end else begin
                    v_nx_s = v_r;
                end
            end
            ST_LEAK: begin
                if (leak != 3'd0) begin
                    v_nx_s = v_r - leak_dv_s;
                end else begin
                    v_nx_s = v_r;
                end
            end
            ST_CMP: begin
                if (ref_r != {REF_W{1'b0}}) begin
                    spike_nx_s = 1'b0;
                    ref_nx_s   = ref_r - REF_W'(1);
                end else if (fire_s) begin
                    spike_nx_s = 1'b1;
                    v_nx_s     = {V_W{1'b0}};
                    ref_nx_s   = ref_len;
                end else begin
                    spike_nx_s = 1'b0;
                end
            end
            default: begin
                v_nx_s = v_r;
            end
        endcase
        // A disabled neuron is pinned at rest and never fires.
        if (enb_s) begin
            v_nx_s     = {V_W{1'b0}};
            ref_nx_s   = {REF_W{1'b0}};
            spike_nx_s = 1'b0;
        end else begin
            spike_nx_s = spike_nx_s;
        end
    end

    // Neuron state registers with reset and power-down clear.
    always_ff @(posedge clk) begin
        if (rst || pd) begin
            v_r     <= {V_W{1'b0}};
            ref_r   <= {REF_W{1'b0}};
            spike_r <= 1'b0;
        end else begin
            v_r     <= v_nx_s;
            ref_r   <= ref_nx_s;
            spike_r <= spike_nx_s;
        end
    end

endmodule

// File: rtl/cim_neuron_array.sv
// Array of N_NEURON integrate-and-fire neurons fed by tiled partial sums, with a
// time-step FSM and a REQ/ACK handshake on the spike vector.
module cim_neuron_array
    import cim_neuron_array_pkg::*;
#(
    parameter int N_NEURON = 16,
    parameter int DV_W     = 6,
    parameter int V_W      = 7,
    parameter int REF_W    = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [N_NEURON*(V_W+1)-1:0]   NCFG,
    input  logic                          SWP,
    input  logic                          PD,
    input  logic                          EN,
    input  logic                          FT,
    input  logic                          TILE_VALID,
    input  logic                          TILE_LAST,
    input  logic [N_NEURON*DV_W-1:0]      DV,
    input  logic [2:0]                    LEAK,
    input  logic [REF_W-1:0]              REF_LEN,
    input  logic                          ACK,
    output logic                          REQ,
    output logic [N_NEURON-1:0]           NEURON_OUT,
    output logic                          BUSY
);

    localparam int CFG_W = ncfg_field_w(V_W);

    state_t              state_r;
    logic                req_r;
    logic                busy_r;
    logic                clr_s;
    logic [N_NEURON-1:0] spike_s;

    assign clr_s      = (state_r == ST_IDLE) && EN && FT;
    assign REQ        = req_r;
    assign BUSY       = busy_r;
    assign NEURON_OUT = spike_s;

    // Time-step sequencer; REQ and BUSY are registered alongside the state.
    always_ff @(posedge CLK) begin
        if (RST || PD) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (EN) begin
                        state_r <= ST_INT;
                        busy_r  <= 1'b1;
                    end
                end
                ST_INT: begin
                    if (TILE_VALID && TILE_LAST) begin
                        state_r <= ST_LEAK;
                    end
                end
                ST_LEAK: begin
                    state_r <= ST_CMP;
                end
                ST_CMP: begin
                    state_r <= ST_HOLD;
                    req_r   <= 1'b1;
                end
                ST_HOLD: begin
                    if (ACK) begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_NEURON; i++) begin : g_cell
        cim_neuron_cell #(
            .DV_W  (DV_W),
            .V_W   (V_W),
            .REF_W (REF_W)
        ) u_cell (
            .clk        (CLK),
            .rst        (RST),
            .pd         (PD),
            .clr        (clr_s),
            .st         (state_r),
            .tile_valid (TILE_VALID),
            .cfg        (NCFG[i*CFG_W +: CFG_W]),
            .swp        (SWP),
            .dv         (DV[i*DV_W +: DV_W]),
            .leak       (LEAK),
            .ref_len    (REF_LEN),
            .spike      (spike_s[i])
        );
    end

endmodule

// File: tb/tb_cim_neuron_array.sv
// Scoreboard bench for cim_neuron_array: a behavioural neuron model predicts each
// time step's spike vector, which is compared when the DUT raises REQ.
module tb_cim_neuron_array;

    localparam int N     = 16;
    localparam int DV_W  = 7;
    localparam int V_W   = 7;
    localparam int REF_W = 3;
    localparam int VMAX  = 63;

    logic                   CLK = 1'b0;
    logic                   RST, PD, EN, FT, TILE_VALID, TILE_LAST, SWP, ACK;
    logic [N*(V_W+1)-1:0]   NCFG;
    logic [N*DV_W-1:0]      DV;
    logic [2:0]             LEAK;
    logic [REF_W-1:0]       REF_LEN;
    logic                   REQ, BUSY;
    logic [N-1:0]           NEURON_OUT;

    int checks = 0;
    int errors = 0;

    int  mv[N];
    int  mref[N];
    int  vth[N];
    bit  enb[N];
    logic [N*DV_W-1:0] tile_q[$];
    logic [N-1:0]      exp_q[$];

    always #5 CLK = ~CLK;

    cim_neuron_array #(.N_NEURON(N), .DV_W(DV_W), .V_W(V_W), .REF_W(REF_W)) dut (
        .CLK(CLK), .RST(RST), .NCFG(NCFG), .SWP(SWP), .PD(PD), .EN(EN), .FT(FT),
        .TILE_VALID(TILE_VALID), .TILE_LAST(TILE_LAST), .DV(DV), .LEAK(LEAK),
        .REF_LEN(REF_LEN), .ACK(ACK), .REQ(REQ), .NEURON_OUT(NEURON_OUT), .BUSY(BUSY)
    );

    function automatic int msat(input int x);
        if (x > VMAX) return VMAX;
        else if (x < -VMAX) return -VMAX;
        else return x;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            mref[i] = 0;
        end
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < N; i++) NCFG[i*(V_W+1) +: V_W+1] = {enb[i], V_W'(vth[i])};
    endtask

    // Neuron 3 is always disabled; neuron 0 gets a chosen threshold, the rest random.
    task automatic rand_cfg(input int vth0);
        for (int i = 0; i < N; i++) begin
            vth[i] = int'($urandom_range(0, 126)) - 63;
            enb[i] = (i == 3);
        end
        vth[0] = vth0;
        apply_cfg();
    endtask

    task automatic push_tile(input int dv0);
        logic [N*DV_W-1:0] t;
        for (int i = 0; i < N; i++) begin
            if (i == 0) t[i*DV_W +: DV_W] = DV_W'(dv0);
            else if (i == 3) t[i*DV_W +: DV_W] = DV_W'(63);
            else t[i*DV_W +: DV_W] = DV_W'($urandom_range(0, 127));
        end
        tile_q.push_back(t);
    endtask

    // Runs one time step with all queued tiles and checks the spike vector at REQ.
    task automatic do_step(input bit ft, input int exp0, output logic [N-1:0] exp_out);
        logic [N*DV_W-1:0] t;
        logic [N-1:0] exp_v;
        logic [N-1:0] got;
        int n;
        int cyc;
        @(negedge CLK);
        EN = 1'b1;
        FT = ft;
        if (ft) model_clear();
        @(negedge CLK);
        EN = 1'b0;
        FT = 1'b0;
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL busy_in_int: got %b want 1", BUSY); end
        n = tile_q.size();
        for (int k = 0; k < n; k++) begin
            t = tile_q.pop_front();
            DV = t;
            TILE_VALID = 1'b1;
            TILE_LAST = (k == n - 1);
            for (int i = 0; i < N; i++) begin
                if (enb[i]) mv[i] = 0;
                else if (mref[i] == 0) mv[i] = msat(mv[i] + int'($signed(t[i*DV_W +: DV_W])));
            end
            @(negedge CLK);
        end
        TILE_VALID = 1'b0;
        TILE_LAST = 1'b0;
        DV = '0;
        for (int i = 0; i < N; i++) begin
            exp_v[i] = 1'b0;
            if (LEAK != 3'd0) mv[i] = mv[i] - (mv[i] >>> LEAK);
            if (enb[i]) begin
                mv[i] = 0;
                mref[i] = 0;
            end else if (mref[i] != 0) begin
                mref[i]--;
            end else if (SWP ? (mv[i] <= vth[i]) : (mv[i] >= vth[i])) begin
                exp_v[i] = 1'b1;
                mv[i] = 0;
                mref[i] = int'(REF_LEN);
            end
        end
        exp_q.push_back(exp_v);
        cyc = 0;
        while (REQ !== 1'b1 && cyc < 8) begin
            @(negedge CLK);
            cyc++;
        end
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL req_latency: got %0d cycles after LEAK want 2", cyc); end
        exp_out = exp_q.pop_front();
        got = NEURON_OUT;
        checks++;
        if (got !== exp_out) begin errors++; $display("FAIL spike_vector: got %h want %h", got, exp_out); end
        if (exp0 >= 0) begin
            checks++;
            if (got[0] !== exp0[0]) begin errors++; $display("FAIL spike0: got %b want %b", got[0], exp0[0]); end
        end
        checks++;
        if (got[3] !== 1'b0) begin errors++; $display("FAIL disabled3: got %b want 0", got[3]); end
    endtask

    task automatic ack_step();
        @(negedge CLK);
        ACK = 1'b1;
        @(negedge CLK);
        ACK = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || REQ !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle: got busy=%b req=%b want 0 0", BUSY, REQ);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (REQ !== 1'b0 || BUSY !== 1'b0 || NEURON_OUT !== '0) begin
            errors++;
            $display("FAIL reset: got req=%b busy=%b out=%h want 0 0 0", REQ, BUSY, NEURON_OUT);
        end
        RST = 1'b0;
        model_clear();
    endtask

    task automatic test_integrate_fire();
        logic [N-1:0] e;
        SWP = 1'b0; LEAK = 3'd0; REF_LEN = '0;
        rand_cfg(40);
        repeat (3) push_tile(20);
        do_step(1'b1, 1, e);
        ack_step();
        vth[0] = 1;
        apply_cfg();
        push_tile(0);
        do_step(1'b0, 0, e);
        ack_step();
    endtask

    task automatic test_saturation();
        logic [N-1:0] e;
        SWP = 1'b0;
        rand_cfg(63);
        push_tile(50); push_tile(50);
        do_step(1'b1, 1, e);
        ack_step();
        SWP = 1'b1;
        rand_cfg(-64);
        repeat (3) push_tile(-31);
        do_step(1'b1, 0, e);
        ack_step();
        vth[0] = -63;
        apply_cfg();
        push_tile(0);
        do_step(1'b0, 1, e);
        ack_step();
        SWP = 1'b0;
    endtask

    task automatic test_leak();
        logic [N-1:0] e;
        LEAK = 3'd0;
        rand_cfg(63);
        push_tile(20); push_tile(20);
        do_step(1'b1, 0, e);
        ack_step();
        LEAK = 3'd2;
        vth[0] = 31;
        apply_cfg();
        push_tile(0);
        do_step(1'b0, 0, e);
        ack_step();
        LEAK = 3'd0;
        vth[0] = 30;
        apply_cfg();
        push_tile(0);
        do_step(1'b0, 1, e);
        ack_step();
    endtask

    task automatic test_refractory();
        logic [N-1:0] e;
        REF_LEN = 3'd2;
        rand_cfg(40);
        push_tile(50); do_step(1'b1, 1, e); ack_step();
        push_tile(50); do_step(1'b0, 0, e); ack_step();
        push_tile(50); do_step(1'b0, 0, e); ack_step();
        push_tile(20); do_step(1'b0, 0, e); ack_step();
        push_tile(20); do_step(1'b0, 1, e); ack_step();
        REF_LEN = '0;
    endtask

    task automatic test_hold();
        logic [N-1:0] e;
        rand_cfg(40);
        push_tile(50);
        do_step(1'b1, 1, e);
        for (int c = 0; c < 5; c++) begin
            EN = (c % 2 == 0);
            FT = 1'b1;
            @(negedge CLK);
            checks++;
            if (REQ !== 1'b1 || BUSY !== 1'b1 || NEURON_OUT !== e) begin
                errors++;
                $display("FAIL hold_stable: got req=%b busy=%b out=%h want 1 1 %h", REQ, BUSY, NEURON_OUT, e);
            end
        end
        EN = 1'b0;
        FT = 1'b0;
        ack_step();
    endtask

    task automatic test_abort(input bit use_pd);
        logic [N-1:0] e;
        SWP = 1'b0;
        rand_cfg(63);
        @(negedge CLK);
        EN = 1'b1; FT = 1'b1;
        @(negedge CLK);
        EN = 1'b0; FT = 1'b0;
        push_tile(25);
        DV = tile_q.pop_front();
        TILE_VALID = 1'b1;
        @(negedge CLK);
        TILE_VALID = 1'b0;
        DV = '0;
        if (use_pd) PD = 1'b1;
        else RST = 1'b1;
        @(negedge CLK);
        PD = 1'b0;
        RST = 1'b0;
        model_clear();
        checks++;
        if (BUSY !== 1'b0 || REQ !== 1'b0 || NEURON_OUT !== '0) begin
            errors++;
            $display("FAIL abort_int pd=%0d: got busy=%b req=%b out=%h want 0 0 0", use_pd, BUSY, REQ, NEURON_OUT);
        end
        SWP = 1'b1;
        rand_cfg(0);
        push_tile(0);
        do_step(1'b0, 1, e);
        ack_step();
        SWP = 1'b0;
    endtask

    task automatic test_rst_in_hold();
        logic [N-1:0] e;
        rand_cfg(40);
        push_tile(50);
        do_step(1'b1, 1, e);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_clear();
        checks++;
        if (REQ !== 1'b0 || BUSY !== 1'b0 || NEURON_OUT !== '0) begin
            errors++;
            $display("FAIL rst_in_hold: got req=%b busy=%b out=%h want 0 0 0", REQ, BUSY, NEURON_OUT);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] e;
        for (int s = 0; s < 12; s++) begin
            SWP = 1'($urandom_range(0, 1));
            LEAK = 3'($urandom_range(0, 3));
            REF_LEN = REF_W'($urandom_range(0, 3));
            rand_cfg(int'($urandom_range(0, 126)) - 63);
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) push_tile(int'($urandom_range(0, 127)) - 64);
            do_step(s == 0, -1, e);
            ack_step();
        end
    endtask

    initial begin
        RST = 1'b1; PD = 1'b0; EN = 1'b0; FT = 1'b0; TILE_VALID = 1'b0; TILE_LAST = 1'b0;
        SWP = 1'b0; ACK = 1'b0; DV = '0; LEAK = 3'd0; REF_LEN = '0; NCFG = '0;
        test_reset();
        test_integrate_fire();
        test_saturation();
        test_leak();
        test_refractory();
        test_hold();
        test_abort(1'b0);
        test_abort(1'b1);
        test_rst_in_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
